// File: rtl/mem_pkg.sv
// Shared memory constants and the address-width helper used by the RAM blocks.
package mem_pkg;

  localparam int SRAM_WIDTH  = 32;
  localparam int SRAM_LENGTH = 256;

  // Bits needed to address 'value' entries; returns at least 1 so a 1-bit port always exists.
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    if (r == 0) r = 1;
    return r;
  endfunction

endpackage

// File: rtl/sram_addr_chk.sv
// Combinational in-range decode for memories whose depth is not a power of two.
module sram_addr_chk
  import mem_pkg::*;
#(
  parameter int LENGTH = SRAM_LENGTH,
  parameter int ADDR_W = clog2(LENGTH)
) (
  input  logic [ADDR_W-1:0] i_addr,
  output logic              o_in_range
);

  assign o_in_range = (int'(i_addr) < LENGTH);

endmodule

// File: rtl/sram_sp.sv
// Single-port synchronous RAM: synchronous write, registered read-first output,
// asynchronous active-low reset clearing both the array and the output register.
module sram_sp
  import mem_pkg::*;
#(
  parameter int WIDTH  = SRAM_WIDTH,
  parameter int LENGTH = SRAM_LENGTH,
  parameter int ADDR_W = clog2(LENGTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              WE,
  input  logic [ADDR_W-1:0] addr,
  input  logic [WIDTH-1:0]  data_in,
  output logic [WIDTH-1:0]  data_out
);

  logic [WIDTH-1:0] r_mem [LENGTH];
  logic [WIDTH-1:0] r_data_p1;
  logic             w_in_range;

  sram_addr_chk #(
    .LENGTH (LENGTH),
    .ADDR_W (ADDR_W)
  ) u_addr_chk (
    .i_addr     (addr),
    .o_in_range (w_in_range)
  );

  // Stage p1: read sees the array before this edge's write; out-of-range reads return zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data_p1 <= '0;
      for (int i = 0; i < LENGTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      r_data_p1 <= w_in_range ? r_mem[addr] : '0;
      if (WE && w_in_range) begin
        r_mem[addr] <= data_in;
      end
    end
  end

  assign data_out = r_data_p1;

endmodule

// File: tb/tb_sram_sp.sv
// Directed bench for sram_sp: 256-deep default instance plus a 200-deep instance.
module tb_sram_sp;

  logic        clk;
  logic        rst_n;
  logic        we;
  logic [7:0]  addr;
  logic [31:0] din;
  logic [31:0] dout;
  logic        we2;
  logic [7:0]  addr2;
  logic [31:0] din2;
  logic [31:0] dout2;

  int errors;
  int checks;

  sram_sp dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .WE       (we),
    .addr     (addr),
    .data_in  (din),
    .data_out (dout)
  );

  sram_sp #(.WIDTH(32), .LENGTH(200)) dut200 (
    .clk      (clk),
    .rst_n    (rst_n),
    .WE       (we2),
    .addr     (addr2),
    .data_in  (din2),
    .data_out (dout2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One access on the 256-deep instance; returns 1 ns after the edge.
  task automatic access(input logic w, input logic [7:0] a, input logic [31:0] d);
    we   = w;
    addr = a;
    din  = d;
    @(posedge clk);
    #1;
  endtask

  task automatic access2(input logic w, input logic [7:0] a, input logic [31:0] d);
    we2   = w;
    addr2 = a;
    din2  = d;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] pat(input int i);
    logic [31:0] p;
    p = (32'h1 << (i % 32)) | (32'h1 << (31 - (i % 32)));
    return p;
  endfunction

  task automatic test_reset();
    #1;
    checks++;
    if (dout !== 32'h0) begin
      errors++;
      $display("FAIL reset_dout: got %h expected %h", dout, 32'h0);
    end
    checks++;
    if (dout2 !== 32'h0) begin
      errors++;
      $display("FAIL reset_dout200: got %h expected %h", dout2, 32'h0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    access(1'b0, 8'd0, 32'h0);
    checks++;
    if (dout !== 32'h0) begin
      errors++;
      $display("FAIL reset_read0: got %h expected %h", dout, 32'h0);
    end
    access(1'b0, 8'd1, 32'h0);
    checks++;
    if (dout !== 32'h0) begin
      errors++;
      $display("FAIL reset_read1: got %h expected %h", dout, 32'h0);
    end
    access(1'b0, 8'd255, 32'h0);
    checks++;
    if (dout !== 32'h0) begin
      errors++;
      $display("FAIL reset_read255: got %h expected %h", dout, 32'h0);
    end
  endtask

  task automatic test_sweep();
    for (int i = 0; i < 256; i++) begin
      access(1'b1, i[7:0], pat(i));
      checks++;
      if (dout !== 32'h0) begin
        errors++;
        $display("FAIL sweep_write_old[%0d]: got %h expected %h", i, dout, 32'h0);
      end
    end
    for (int i = 0; i < 256; i++) begin
      access(1'b0, i[7:0], 32'h0);
      checks++;
      if (dout !== pat(i)) begin
        errors++;
        $display("FAIL sweep_read[%0d]: got %h expected %h", i, dout, pat(i));
      end
    end
  endtask

  task automatic test_reset_mid();
    // dout currently holds pat(255) = 0x80000001
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (dout !== 32'h0) begin
      errors++;
      $display("FAIL reset_mid_dout: got %h expected %h", dout, 32'h0);
    end
    #1;
    rst_n = 1'b1;
    access(1'b0, 8'd100, 32'h0);
    checks++;
    if (dout !== 32'h0) begin
      errors++;
      $display("FAIL reset_mid_read100: got %h expected %h", dout, 32'h0);
    end
    access(1'b0, 8'd5, 32'h0);
    checks++;
    if (dout !== 32'h0) begin
      errors++;
      $display("FAIL reset_mid_read5: got %h expected %h", dout, 32'h0);
    end
  endtask

  task automatic test_isolation();
    access(1'b1, 8'd10, 32'hDEADBEEF);
    access(1'b0, 8'd9, 32'h0);
    checks++;
    if (dout !== 32'h0) begin
      errors++;
      $display("FAIL iso_read9: got %h expected %h", dout, 32'h0);
    end
    access(1'b0, 8'd11, 32'h0);
    checks++;
    if (dout !== 32'h0) begin
      errors++;
      $display("FAIL iso_read11: got %h expected %h", dout, 32'h0);
    end
    for (int k = 0; k < 4; k++) begin
      access(1'b0, 8'd10, 32'h1111_0000 + k);
      checks++;
      if (dout !== 32'hDEADBEEF) begin
        errors++;
        $display("FAIL iso_hold10[%0d]: got %h expected %h", k, dout, 32'hDEADBEEF);
      end
    end
    // Address wiggle between edges must not disturb the registered output.
    addr = 8'd9;
    #2;
    addr = 8'd10;
    #1;
    checks++;
    if (dout !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL iso_glitch: got %h expected %h", dout, 32'hDEADBEEF);
    end
  endtask

  task automatic test_read_first();
    access(1'b1, 8'd7, 32'h0000FFFF);
    access(1'b1, 8'd7, 32'hA5A5A5A5);
    checks++;
    if (dout !== 32'h0000FFFF) begin
      errors++;
      $display("FAIL read_first_old: got %h expected %h", dout, 32'h0000FFFF);
    end
    access(1'b0, 8'd7, 32'h0);
    checks++;
    if (dout !== 32'hA5A5A5A5) begin
      errors++;
      $display("FAIL read_first_new: got %h expected %h", dout, 32'hA5A5A5A5);
    end
  endtask

  task automatic test_back_to_back();
    access(1'b1, 8'd20, 32'h11112222);
    access(1'b0, 8'd20, 32'h0);
    checks++;
    if (dout !== 32'h11112222) begin
      errors++;
      $display("FAIL b2b_read20: got %h expected %h", dout, 32'h11112222);
    end
    access(1'b1, 8'd21, 32'h33334444);
    access(1'b1, 8'd22, 32'h55556666);
    access(1'b0, 8'd21, 32'h0);
    checks++;
    if (dout !== 32'h33334444) begin
      errors++;
      $display("FAIL b2b_read21: got %h expected %h", dout, 32'h33334444);
    end
    access(1'b0, 8'd22, 32'h0);
    checks++;
    if (dout !== 32'h55556666) begin
      errors++;
      $display("FAIL b2b_read22: got %h expected %h", dout, 32'h55556666);
    end
  endtask

  task automatic test_nonpow2();
    access2(1'b1, 8'd199, 32'hCAFEF00D);
    access2(1'b1, 8'd210, 32'h12345678);
    checks++;
    if (dout2 !== 32'h0) begin
      errors++;
      $display("FAIL np2_write210_out: got %h expected %h", dout2, 32'h0);
    end
    access2(1'b0, 8'd210, 32'h0);
    checks++;
    if (dout2 !== 32'h0) begin
      errors++;
      $display("FAIL np2_read210: got %h expected %h", dout2, 32'h0);
    end
    access2(1'b0, 8'd10, 32'h0);
    checks++;
    if (dout2 !== 32'h0) begin
      errors++;
      $display("FAIL np2_read10: got %h expected %h", dout2, 32'h0);
    end
    access2(1'b0, 8'd199, 32'h0);
    checks++;
    if (dout2 !== 32'hCAFEF00D) begin
      errors++;
      $display("FAIL np2_read199: got %h expected %h", dout2, 32'hCAFEF00D);
    end
    // Out-of-range read must zero the output even right after a valid read.
    access2(1'b0, 8'd200, 32'h0);
    checks++;
    if (dout2 !== 32'h0) begin
      errors++;
      $display("FAIL np2_read200: got %h expected %h", dout2, 32'h0);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst_n  = 1'b0;
    we     = 1'b0;
    addr   = 8'd0;
    din    = 32'h0;
    we2    = 1'b0;
    addr2  = 8'd0;
    din2   = 32'h0;
    test_reset();
    test_sweep();
    test_reset_mid();
    test_isolation();
    test_read_first();
    test_back_to_back();
    test_nonpow2();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
